regfile_scoreboard: RTL
=======================

// Module: regfile_scoreboard
// PURPOSE
// - Parametrised integer register file: NRD read ports, one write port, hardwired x0.
// - Combinational or registered reads, with write-to-read forwarding in both modes.
// - Built-in per-register pending scoreboard. Decode marks a destination pending at issue; writeback clears it.
// - Sits between decode (reads, issue) and writeback (write) in the RV32I core.
// PARAMETERS
// - XLEN      32  data width in bits
// - DEPTH     32  number of registers; power of two, >= 2
// - AW        5   address width; must equal $clog2(DEPTH)
// - NRD       2   number of read ports, 1..4
// - READ_LAT  0   0 = combinational read; 1 = read data/busy registered (1-cycle latency)
// PORTS
// - clk        in   1         rising-edge clock
// - rst        in   1         synchronous, active-high reset
// - we         in   1         write enable
// - WriteAddr  in   AW        write register index
// - WriteData  in   XLEN      write data
// - ReadEn     in   NRD       per-port read enable
// - ReadAddr   in   NRD*AW    port p uses bits [p*AW +: AW]
// - ReadData   out  NRD*XLEN  port p uses bits [p*XLEN +: XLEN]
// - ReadBusy   out  NRD       port p's source register is still pending
// - sb_set     in   1         mark sb_addr pending (instruction issued)
// - sb_addr    in   AW        destination register being issued
// - sb_flush   in   1         clear all pending bits (pipeline flush)
// - busy_vec   out  DEPTH     pending bit per register; bit 0 always 0
// - pend_cnt   out  AW+1      number of set bits in busy_vec
// BEHAVIOUR
// - Reset (rst=1 at a rising edge):
//   - all registers, busy_vec, pend_cnt and registered outputs go to 0;
//   - while rst=1, ReadData and ReadBusy read 0 in both modes;
//   - reset overrides a write, sb_set or sb_flush in the same cycle.
// - Write:
//   - at posedge, if we && WriteAddr!=0, then reg[WriteAddr] <= WriteData;
//   - writes to x0 are discarded.
// - Read value rd(p):
//   - 0 if !ReadEn[p] or ReadAddr_p==0;
//   - else WriteData if we && WriteAddr==ReadAddr_p (forwarding);
//   - else reg[ReadAddr_p].
// - READ_LAT=0: ReadData_p = rd(p), combinational, same cycle.
// - READ_LAT=1: ReadData_p is rd(p) sampled at posedge, valid in the following cycle.
//   - Result equals the array contents after that edge's write.
// - Scoreboard, evaluated per register i at posedge, highest priority first:
//   - sb_flush: busy[i] <= 0 (flush beats a simultaneous set);
//   - sb_set && sb_addr==i && i!=0: busy[i] <= 1 (set beats a same-cycle clearing write);
//   - we && WriteAddr==i: busy[i] <= 0;
//   - otherwise busy[i] is held.
// - ReadBusy_p = ReadEn[p] && ReadAddr_p!=0 && busy[ReadAddr_p] && !(we && WriteAddr==ReadAddr_p).
//   - A forwarded write resolves the hazard in the same cycle.
//   - Timing follows READ_LAT: combinational, or registered alongside ReadData.
// - pend_cnt is a registered count, updated each cycle.
//   - +1 when a set hits a clear bit; -1 when a write clears a set bit; both may occur in one cycle.
//   - Flush sets it to 0; it never exceeds DEPTH-1.
// - Multiple read ports may name the same register; each gets identical data/busy.
// - Writing a non-pending register is legal and leaves pend_cnt unchanged.
// TESTING
// - Reset, then READ_LAT=0:
//   - write x5=0xDEADBEEF, then read port0 x5 -> 0xDEADBEEF;
//   - write x0=0x1234 -> x0 reads 0.
// - Forwarding:
//   - same cycle we=1, WriteAddr=7, WriteData=0xA5A5A5A5, ReadAddr0=ReadAddr1=7;
//   - both ports return 0xA5A5A5A5: same cycle for LAT=0, next cycle for LAT=1.
// - Scoreboard:
//   - sb_set x3, then x4 -> busy_vec=0x18, pend_cnt=2;
//   - write x3 -> busy_vec=0x10, pend_cnt=1;
//   - sb_set x0 -> no change.
// - Simultaneous events:
//   - sb_set x9 with we x9 in one cycle -> busy[9]=1, pend_cnt +1;
//   - then sb_flush with sb_set x2 -> busy_vec=0, pend_cnt=0.
// - ReadBusy:
//   - x6 pending, read x6 -> ReadBusy=1;
//   - the cycle x6 is written and read -> ReadBusy=0, ReadData=WriteData.
// - Mid-operation reset:
//   - 3 pending registers and nonzero contents, assert rst with we=1;
//   - next cycle all reads 0, busy_vec=0, pend_cnt=0.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - decode/writeback bus for the register file with pending scoreboard
interface regfile_scoreboard_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int NRD   = 2
);
    logic              we;
    logic [AW-1:0]     WriteAddr;
    logic [XLEN-1:0]   WriteData;
    logic [NRD-1:0]    ReadEn;
    logic [NRD*AW-1:0] ReadAddr;
    logic [NRD*XLEN-1:0] ReadData;
    logic [NRD-1:0]    ReadBusy;
    logic              sb_set;
    logic [AW-1:0]     sb_addr;
    logic              sb_flush;
    logic [DEPTH-1:0]  busy_vec;
    logic [AW:0]       pend_cnt;

    modport master (
        output we, WriteAddr, WriteData, ReadEn, ReadAddr, sb_set, sb_addr, sb_flush,
        input  ReadData, ReadBusy, busy_vec, pend_cnt
    );

    modport slave (
        input  we, WriteAddr, WriteData, ReadEn, ReadAddr, sb_set, sb_addr, sb_flush,
        output ReadData, ReadBusy, busy_vec, pend_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with hardwired x0, write forwarding and pending scoreboard
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int READ_LAT = 0
) (
    input  logic clk,
    input  logic rst,
    regfile_scoreboard_if.slave bus
);
    logic [XLEN-1:0]     regs [DEPTH];
    logic [DEPTH-1:0]    busy;
    logic [AW:0]         cnt;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                inc;
    logic                dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (bus.we && bus.WriteAddr != '0) begin
            regs[bus.WriteAddr] <= bus.WriteData;
        end
    end

    // A same-register set keeps the bit pending, so the write does not count as a clear.
    assign inc = bus.sb_set && bus.sb_addr != '0 && !busy[bus.sb_addr];
    assign dec = bus.we && busy[bus.WriteAddr] &&
                 !(bus.sb_set && bus.sb_addr == bus.WriteAddr);

    always_ff @(posedge clk) begin
        if (rst || bus.sb_flush) begin
            busy <= '0;
            cnt  <= '0;
        end else begin
            if (bus.we) busy[bus.WriteAddr] <= 1'b0;
            if (bus.sb_set && bus.sb_addr != '0) busy[bus.sb_addr] <= 1'b1;
            cnt <= cnt + (AW+1)'(inc) - (AW+1)'(dec);
        end
    end

    assign bus.busy_vec = busy;
    assign bus.pend_cnt = cnt;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit;
        logic          fwd;
        assign ra  = bus.ReadAddr[p*AW +: AW];
        assign hit = bus.ReadEn[p] && ra != '0;
        assign fwd = bus.we && bus.WriteAddr == ra;
        assign rd_data[p*XLEN +: XLEN] = !hit ? '0 : (fwd ? bus.WriteData : regs[ra]);
        assign rd_busy[p] = hit && busy[ra] && !fwd;
    end

    if (READ_LAT == 0) begin : g_comb
        assign bus.ReadData = rst ? '0 : rd_data;
        assign bus.ReadBusy = rst ? '0 : rd_busy;
    end else begin : g_reg
        logic [NRD*XLEN-1:0] q_data;
        logic [NRD-1:0]      q_busy;
        always_ff @(posedge clk) begin
            if (rst) begin
                q_data <= '0;
                q_busy <= '0;
            end else begin
                q_data <= rd_data;
                q_busy <= rd_busy;
            end
        end
        assign bus.ReadData = rst ? '0 : q_data;
        assign bus.ReadBusy = rst ? '0 : q_busy;
    end
endmodule
